// File: rtl/quiz_round_controller_pkg.sv
// Shared types for the quiz round controller: FSM state encoding,
// player indices and winner codes.
package quiz_round_controller_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHOW,
    ST_ARMED,
    ST_JUDGE,
    ST_RESULT,
    ST_NEXT,
    ST_DONE
  } state_t;

  // Player index, used for the arbiter grant and the lock vector bit.
  localparam logic P1 = 1'b0;
  localparam logic P2 = 1'b1;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;
  localparam logic [1:0] WIN_TIE  = 2'b11;

  // Final verdict from the two scores; a 0:0 game has no winner.
  function automatic logic [1:0] winner_code(input logic [3:0] s1, input logic [3:0] s2);
    if (s1 > s2)
      return WIN_P1;
    else if (s2 > s1)
      return WIN_P2;
    else if (s1 != 4'd0)
      return WIN_TIE;
    else
      return WIN_NONE;
  endfunction

endpackage

// File: rtl/quiz_round_controller_answer_arbiter.sv
// Two-player answer arbiter: masks locked players, resolves simultaneous
// presses with a flipping priority, and latches the winning player/answer.
module quiz_round_controller_answer_arbiter
  import quiz_round_controller_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       p1_valid,
  input  logic [3:0] p1_ans,
  input  logic       p2_valid,
  input  logic [3:0] p2_ans,
  input  logic       lock_grant,
  input  logic       clear_locks,
  output logic       accept,
  output logic       grant,
  output logic [3:0] grant_ans,
  output logic [1:0] locks
);

  logic req1;
  logic req2;
  logic pick;
  logic prio;

  // Qualify requests with the window and lock mask, then pick a winner.
  always_comb begin
    req1   = en & p1_valid & ~locks[P1];
    req2   = en & p2_valid & ~locks[P2];
    accept = req1 | req2;
    if (req1 && req2)
      pick = prio;
    else if (req2)
      pick = P2;
    else
      pick = P1;
  end

  // Latch the accepted press, rotate priority on conflicts, maintain locks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant     <= P1;
      grant_ans <= 4'd0;
      prio      <= P1;
      locks     <= 2'b00;
    end else begin
      if (accept) begin
        grant     <= pick;
        grant_ans <= (pick == P2) ? p2_ans : p1_ans;
      end
      // Only a genuine collision hands priority to the other player.
      if (req1 && req2)
        prio <= ~pick;
      if (clear_locks)
        locks <= 2'b00;
      else if (lock_grant)
        locks[grant] <= 1'b1;
    end
  end

endmodule

// File: rtl/quiz_round_controller.sv
// Quiz round controller: walks the question index, times the answer window,
// judges the arbitrated answer, keeps scores and decides the game result.
module quiz_round_controller
  import quiz_round_controller_pkg::*;
#(
  parameter int NUM_Q          = 10,
  parameter int WIN_SCORE      = 5,
  parameter int SHOW_CYCLES    = 4,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int RESULT_CYCLES  = 8,
  parameter int CNT_W          = 16
)
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       p1_valid,
  input  logic [3:0] p1_ans,
  input  logic       p2_valid,
  input  logic [3:0] p2_ans,
  input  logic [3:0] q_ans,
  output logic [3:0] bcd_state,
  output logic       armed,
  output logic       p1_inc,
  output logic       p2_inc,
  output logic [3:0] p1_score,
  output logic [3:0] p2_score,
  output logic       beep,
  output logic       busy,
  output logic       game_over,
  output logic [1:0] winner
);

  localparam logic [CNT_W-1:0] SHOW_LOAD    = CNT_W'(SHOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] RESULT_LOAD  = CNT_W'(RESULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMR_ONE      = CNT_W'(1);
  localparam logic [3:0]       LAST_Q       = 4'(NUM_Q - 1);
  localparam logic [3:0]       WIN_S        = 4'(WIN_SCORE);

  state_t           state;
  logic [CNT_W-1:0] timer;
  logic             accept;
  logic             grant;
  logic [3:0]       grant_ans;
  logic [1:0]       locks;
  logic             lock_grant;
  logic             clear_locks;
  logic             correct;
  logic             other_locked;

  // Judge the latched answer and derive arbiter lock control from the state.
  always_comb begin
    correct      = (grant_ans == q_ans);
    other_locked = (grant == P1) ? locks[P2] : locks[P1];
    lock_grant   = (state == ST_JUDGE) && !correct;
    clear_locks  = (state == ST_NEXT) ||
                   (((state == ST_IDLE) || (state == ST_DONE)) && start);
  end

  quiz_round_controller_answer_arbiter u_arbiter (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (state == ST_ARMED),
    .p1_valid    (p1_valid),
    .p1_ans      (p1_ans),
    .p2_valid    (p2_valid),
    .p2_ans      (p2_ans),
    .lock_grant  (lock_grant),
    .clear_locks (clear_locks),
    .accept      (accept),
    .grant       (grant),
    .grant_ans   (grant_ans),
    .locks       (locks)
  );

  // Game sequencer with the shared timer, scores and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      timer     <= '0;
      bcd_state <= 4'd0;
      armed     <= 1'b0;
      p1_inc    <= 1'b0;
      p2_inc    <= 1'b0;
      p1_score  <= 4'd0;
      p2_score  <= 4'd0;
      beep      <= 1'b0;
      busy      <= 1'b0;
      game_over <= 1'b0;
      winner    <= WIN_NONE;
    end else begin
      // Score pulses last exactly one cycle.
      p1_inc <= 1'b0;
      p2_inc <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state     <= ST_SHOW;
            timer     <= SHOW_LOAD;
            bcd_state <= 4'd0;
            p1_score  <= 4'd0;
            p2_score  <= 4'd0;
            beep      <= 1'b0;
            busy      <= 1'b1;
            game_over <= 1'b0;
            winner    <= WIN_NONE;
          end
        end
        ST_SHOW: begin
          if (timer == '0) begin
            state <= ST_ARMED;
            timer <= TIMEOUT_LOAD;
            armed <= 1'b1;
          end else begin
            timer <= timer - TMR_ONE;
          end
        end
        ST_ARMED: begin
          beep <= 1'b0;
          if (accept) begin
            state <= ST_JUDGE;
            armed <= 1'b0;
            if (timer != '0)
              timer <= timer - TMR_ONE;
          end else if (timer == '0) begin
            state <= ST_RESULT;
            timer <= RESULT_LOAD;
            armed <= 1'b0;
            beep  <= 1'b1;
          end else begin
            timer <= timer - TMR_ONE;
          end
        end
        ST_JUDGE: begin
          if (correct) begin
            state <= ST_RESULT;
            timer <= RESULT_LOAD;
            if (grant == P1) begin
              p1_inc <= 1'b1;
              if (p1_score < WIN_S)
                p1_score <= p1_score + 4'd1;
            end else begin
              p2_inc <= 1'b1;
              if (p2_score < WIN_S)
                p2_score <= p2_score + 4'd1;
            end
          end else if (!other_locked) begin
            // Second chance for the other player; the window keeps running.
            state <= ST_ARMED;
            armed <= 1'b1;
            beep  <= 1'b1;
          end else begin
            state <= ST_RESULT;
            timer <= RESULT_LOAD;
            beep  <= 1'b1;
          end
        end
        ST_RESULT: begin
          if (timer == '0) begin
            state <= ST_NEXT;
            beep  <= 1'b0;
          end else begin
            timer <= timer - TMR_ONE;
          end
        end
        ST_NEXT: begin
          if ((p1_score == WIN_S) || (p2_score == WIN_S) || (bcd_state == LAST_Q)) begin
            state     <= ST_DONE;
            busy      <= 1'b0;
            game_over <= 1'b1;
            winner    <= winner_code(p1_score, p2_score);
          end else begin
            state     <= ST_SHOW;
            timer     <= SHOW_LOAD;
            bcd_state <= bcd_state + 4'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_quiz_round_controller.sv
// Directed testbench for quiz_round_controller: plays two scripted games and
// checks pulses, timing, locks, timeouts and final verdicts.
module tb_quiz_round_controller;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       p1_valid;
  logic [3:0] p1_ans;
  logic       p2_valid;
  logic [3:0] p2_ans;
  logic [3:0] q_ans;
  logic [3:0] bcd_state;
  logic       armed;
  logic       p1_inc;
  logic       p2_inc;
  logic [3:0] p1_score;
  logic [3:0] p2_score;
  logic       beep;
  logic       busy;
  logic       game_over;
  logic [1:0] winner;

  int checks   = 0;
  int failures = 0;

  logic [3:0] qtab [10];

  assign q_ans = qtab[bcd_state];

  quiz_round_controller dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .p1_valid  (p1_valid),
    .p1_ans    (p1_ans),
    .p2_valid  (p2_valid),
    .p2_ans    (p2_ans),
    .q_ans     (q_ans),
    .bcd_state (bcd_state),
    .armed     (armed),
    .p1_inc    (p1_inc),
    .p2_inc    (p2_inc),
    .p1_score  (p1_score),
    .p2_score  (p2_score),
    .beep      (beep),
    .busy      (busy),
    .game_over (game_over),
    .winner    (winner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [3:0] wrong_of(input logic [3:0] a);
    return (a == 4'd4) ? 4'd1 : a + 4'd1;
  endfunction

  // One-cycle press; called at a negedge, returns at the next negedge.
  task automatic press(input logic v1, input logic [3:0] a1, input logic v2, input logic [3:0] a2);
    p1_valid = v1; p1_ans = a1; p2_valid = v2; p2_ans = a2;
    @(negedge clk);
    p1_valid = 1'b0; p2_valid = 1'b0;
  endtask

  task automatic wait_armed(input string tag);
    int n;
    n = 0;
    while (armed !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    checks++;
    if (armed !== 1'b1) begin
      failures++;
      $display("FAIL %s wait_armed: armed=%b required 1", tag, armed);
    end
  endtask

  task automatic wait_q_change(input string tag, input logic [3:0] old);
    int n;
    n = 0;
    while (bcd_state === old && game_over !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    checks++;
    if (bcd_state === old && game_over !== 1'b1) begin
      failures++;
      $display("FAIL %s wait_q_change: bcd_state=%0d still, game_over=%b", tag, bcd_state, game_over);
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({armed, busy, beep, game_over, p1_inc, p2_inc, winner, bcd_state, p1_score, p2_score} !== 20'd0) begin
      failures++;
      $display("FAIL reset_state: armed=%b busy=%b beep=%b go=%b bcd=%0d s1=%0d s2=%0d required all 0",
               armed, busy, beep, game_over, bcd_state, p1_score, p2_score);
    end
    $display("reset: outputs checked during reset");
  endtask

  task automatic test_start(input string tag);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (bcd_state !== 4'd0 || busy !== 1'b1 || game_over !== 1'b0 || winner !== 2'b00 ||
        p1_score !== 4'd0 || p2_score !== 4'd0 || armed !== 1'b0) begin
      failures++;
      $display("FAIL %s start_state: bcd=%0d busy=%b go=%b win=%b s1=%0d s2=%0d armed=%b required 0,1,0,00,0,0,0",
               tag, bcd_state, busy, game_over, winner, p1_score, p2_score, armed);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (armed !== 1'b0) begin
      failures++;
      $display("FAIL %s show_hold: armed=%b required 0 in last SHOW cycle", tag, armed);
    end
    @(negedge clk);
    checks++;
    if (armed !== 1'b1) begin
      failures++;
      $display("FAIL %s show_release: armed=%b required 1 after 4 SHOW cycles", tag, armed);
    end
    $display("%s: start -> bcd=%0d armed=%b", tag, bcd_state, armed);
  endtask

  task automatic test_correct_answer();
    press(1'b1, 4'd1, 1'b0, 4'd0);
    checks++;
    if (p1_inc !== 1'b0 || armed !== 1'b0) begin
      failures++;
      $display("FAIL correct_n1: p1_inc=%b armed=%b required 0,0", p1_inc, armed);
    end
    @(negedge clk);
    checks++;
    if (p1_inc !== 1'b1 || p2_inc !== 1'b0 || p1_score !== 4'd1 || beep !== 1'b0) begin
      failures++;
      $display("FAIL correct_n2: p1_inc=%b p2_inc=%b s1=%0d beep=%b required 1,0,1,0", p1_inc, p2_inc, p1_score, beep);
    end
    @(negedge clk);
    checks++;
    if (p1_inc !== 1'b0) begin
      failures++;
      $display("FAIL correct_n3: p1_inc=%b required 0", p1_inc);
    end
    wait_q_change("correct", 4'd0);
    checks++;
    if (bcd_state !== 4'd1 || p1_score !== 4'd1 || p2_score !== 4'd0) begin
      failures++;
      $display("FAIL correct_next: bcd=%0d s1=%0d s2=%0d required 1,1,0", bcd_state, p1_score, p2_score);
    end
    $display("correct: p1 scored, bcd=%0d", bcd_state);
  endtask

  task automatic test_reset_mid_armed();
    wait_armed("mid_reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({armed, busy, beep, game_over, p1_inc, p2_inc, winner, bcd_state, p1_score, p2_score} !== 20'd0) begin
      failures++;
      $display("FAIL mid_reset: armed=%b busy=%b bcd=%0d s1=%0d s2=%0d required all 0",
               armed, busy, bcd_state, p1_score, p2_score);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || armed !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset_idle: busy=%b armed=%b required 0,0", busy, armed);
    end
    $display("mid_reset: asynchronous reset in ARMED");
  endtask

  task automatic play_correct(input string tag, input logic who, input logic [3:0] e1, input logic [3:0] e2);
    logic [3:0] a;
    logic [3:0] q;
    wait_armed(tag);
    q = bcd_state;
    a = qtab[bcd_state];
    if (who == 1'b0) press(1'b1, a, 1'b0, 4'd0);
    else             press(1'b0, 4'd0, 1'b1, a);
    @(negedge clk);
    checks++;
    if ({p1_inc, p2_inc} !== ((who == 1'b0) ? 2'b10 : 2'b01) || p1_score !== e1 || p2_score !== e2) begin
      failures++;
      $display("FAIL %s score: inc=%b%b s1=%0d s2=%0d required inc=%s s1=%0d s2=%0d",
               tag, p1_inc, p2_inc, p1_score, p2_score, (who == 1'b0) ? "10" : "01", e1, e2);
    end
    wait_q_change(tag, q);
    $display("%s: q=%0d winner=P%0d scores %0d:%0d", tag, q, who + 1, p1_score, p2_score);
  endtask

  task automatic test_simultaneous(input string tag, input logic exp_who, input logic [3:0] e1, input logic [3:0] e2);
    logic [3:0] a;
    logic [3:0] q;
    wait_armed(tag);
    q = bcd_state;
    a = qtab[bcd_state];
    press(1'b1, a, 1'b1, a);
    @(negedge clk);
    checks++;
    if ({p1_inc, p2_inc} !== ((exp_who == 1'b0) ? 2'b10 : 2'b01) || p1_score !== e1 || p2_score !== e2) begin
      failures++;
      $display("FAIL %s simultaneous: inc=%b%b s1=%0d s2=%0d required winner P%0d s1=%0d s2=%0d",
               tag, p1_inc, p2_inc, p1_score, p2_score, exp_who + 1, e1, e2);
    end
    wait_q_change(tag, q);
    $display("%s: simultaneous press on q=%0d, scores %0d:%0d", tag, q, p1_score, p2_score);
  endtask

  task automatic test_wrong_lock();
    logic [3:0] a;
    logic [3:0] q;
    wait_armed("wrong_lock");
    q = bcd_state;
    a = qtab[bcd_state];
    press(1'b1, wrong_of(a), 1'b0, 4'd0);
    checks++;
    if (beep !== 1'b0 || armed !== 1'b0) begin
      failures++;
      $display("FAIL wrong_judge: beep=%b armed=%b required 0,0", beep, armed);
    end
    @(negedge clk);
    checks++;
    if (beep !== 1'b1 || armed !== 1'b1 || p1_score !== 4'd2) begin
      failures++;
      $display("FAIL wrong_beep: beep=%b armed=%b s1=%0d required 1,1,2", beep, armed, p1_score);
    end
    press(1'b1, a, 1'b0, 4'd0);
    checks++;
    if (beep !== 1'b0 || armed !== 1'b1) begin
      failures++;
      $display("FAIL wrong_locked_press: beep=%b armed=%b required 0,1", beep, armed);
    end
    @(negedge clk);
    checks++;
    if (p1_inc !== 1'b0 || armed !== 1'b1 || p1_score !== 4'd2) begin
      failures++;
      $display("FAIL wrong_locked_ignored: p1_inc=%b armed=%b s1=%0d required 0,1,2", p1_inc, armed, p1_score);
    end
    press(1'b0, 4'd0, 1'b1, a);
    @(negedge clk);
    checks++;
    if (p2_inc !== 1'b1 || p1_inc !== 1'b0 || p2_score !== 4'd2 || p1_score !== 4'd2) begin
      failures++;
      $display("FAIL wrong_p2_scores: p1_inc=%b p2_inc=%b s1=%0d s2=%0d required 0,1,2,2", p1_inc, p2_inc, p1_score, p2_score);
    end
    wait_q_change("wrong_lock", q);
    $display("wrong_lock: p1 locked on q=%0d, p2 scored, scores %0d:%0d", q, p1_score, p2_score);
  endtask

  task automatic test_timeout();
    int n;
    int b;
    logic [3:0] q;
    wait_armed("timeout");
    q = bcd_state;
    n = 0;
    while (armed === 1'b1 && n < 1100) begin @(negedge clk); n++; end
    checks++;
    if (n != 1000) begin
      failures++;
      $display("FAIL timeout_window: armed cycles=%0d required 1000", n);
    end
    b = 0;
    while (beep === 1'b1 && b < 20) begin @(negedge clk); b++; end
    checks++;
    if (b != 8) begin
      failures++;
      $display("FAIL timeout_beep: beep cycles=%0d required 8", b);
    end
    wait_q_change("timeout", q);
    checks++;
    if (bcd_state !== 4'd5 || p1_score !== 4'd2 || p2_score !== 4'd2) begin
      failures++;
      $display("FAIL timeout_next: bcd=%0d s1=%0d s2=%0d required 5,2,2", bcd_state, p1_score, p2_score);
    end
    $display("timeout: window=%0d beep=%0d bcd=%0d", n, b, bcd_state);
  endtask

  task automatic test_both_wrong(input string tag, input logic [3:0] e1, input logic [3:0] e2);
    int b;
    logic [3:0] a;
    logic [3:0] q;
    wait_armed(tag);
    q = bcd_state;
    a = qtab[bcd_state];
    press(1'b1, wrong_of(a), 1'b0, 4'd0);
    @(negedge clk);
    press(1'b0, 4'd0, 1'b1, wrong_of(a));
    checks++;
    if (beep !== 1'b0 || armed !== 1'b0) begin
      failures++;
      $display("FAIL %s both_wrong_judge: beep=%b armed=%b required 0,0", tag, beep, armed);
    end
    @(negedge clk);
    b = 0;
    while (beep === 1'b1 && b < 20) begin
      if (armed !== 1'b0 || p1_inc !== 1'b0 || p2_inc !== 1'b0) b = 100;
      @(negedge clk);
      b++;
    end
    checks++;
    if (b != 8 || p1_score !== e1 || p2_score !== e2) begin
      failures++;
      $display("FAIL %s both_wrong_result: beep cycles=%0d s1=%0d s2=%0d required 8,%0d,%0d", tag, b, p1_score, p2_score, e1, e2);
    end
    wait_q_change(tag, q);
    $display("%s: both wrong on q=%0d, beep=%0d cycles", tag, q, b);
  endtask

  task automatic test_game_over(input string tag, input logic [1:0] exp_win, input logic [3:0] exp_q,
                                input logic [3:0] e1, input logic [3:0] e2);
    int n;
    n = 0;
    while (game_over !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    checks++;
    if (game_over !== 1'b1 || busy !== 1'b0 || winner !== exp_win || bcd_state !== exp_q ||
        p1_score !== e1 || p2_score !== e2 || armed !== 1'b0) begin
      failures++;
      $display("FAIL %s game_over: go=%b busy=%b win=%b bcd=%0d s1=%0d s2=%0d required 1,0,%b,%0d,%0d,%0d",
               tag, game_over, busy, winner, bcd_state, p1_score, p2_score, exp_win, exp_q, e1, e2);
    end
    $display("%s: done winner=%b bcd=%0d scores %0d:%0d", tag, winner, bcd_state, p1_score, p2_score);
  endtask

  task automatic test_start_ignored();
    wait_armed("start_ignored");
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    checks++;
    if (bcd_state !== 4'd0 || armed !== 1'b1 || busy !== 1'b1 || game_over !== 1'b0) begin
      failures++;
      $display("FAIL start_ignored: bcd=%0d armed=%b busy=%b go=%b required 0,1,1,0", bcd_state, armed, busy, game_over);
    end
    $display("start_ignored: start during ARMED had no effect");
  endtask

  initial begin
    qtab[0] = 4'd1; qtab[1] = 4'd2; qtab[2] = 4'd3; qtab[3] = 4'd4; qtab[4] = 4'd1;
    qtab[5] = 4'd2; qtab[6] = 4'd3; qtab[7] = 4'd4; qtab[8] = 4'd1; qtab[9] = 4'd2;
    rst_n = 1'b0; start = 1'b0;
    p1_valid = 1'b0; p1_ans = 4'd0; p2_valid = 1'b0; p2_ans = 4'd0;
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);

    test_start("start_a");
    test_correct_answer();
    test_reset_mid_armed();
    test_start("start_b");

    // Game 1: ends on the last question with a 4:4 tie.
    play_correct("q0", 1'b0, 4'd1, 4'd0);
    test_simultaneous("sim_a", 1'b0, 4'd2, 4'd0);
    test_simultaneous("sim_b", 1'b1, 4'd2, 4'd1);
    test_wrong_lock();
    test_timeout();
    play_correct("q5", 1'b0, 4'd3, 4'd2);
    play_correct("q6", 1'b1, 4'd3, 4'd3);
    test_both_wrong("q7", 4'd3, 4'd3);
    play_correct("q8", 1'b0, 4'd4, 4'd3);
    play_correct("q9", 1'b1, 4'd4, 4'd4);
    test_game_over("tie", 2'b11, 4'd9, 4'd4, 4'd4);

    // Game 2: P1 reaches the win score on the sixth question.
    test_start("start_c");
    test_start_ignored();
    test_both_wrong("g2q0", 4'd0, 4'd0);
    play_correct("g2q1", 1'b0, 4'd1, 4'd0);
    play_correct("g2q2", 1'b0, 4'd2, 4'd0);
    play_correct("g2q3", 1'b0, 4'd3, 4'd0);
    play_correct("g2q4", 1'b0, 4'd4, 4'd0);
    play_correct("g2q5", 1'b0, 4'd5, 4'd0);
    test_game_over("win", 2'b01, 4'd5, 4'd5, 4'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/quiz_round_controller.md
Name: quiz_round_controller

Overview:
- Sequences one quiz game: steps the question index through the question table, opens a timed answer window, and arbitrates the two player answer inputs.
- Judges the winning answer against the table's expected answer and issues score-increment pulses to the per-player LED score counters.
- Drives the beep and ends the game on win score or last question.

Parameters:
NUM_Q, 10, number of questions; bcd_state runs 0..NUM_Q-1
WIN_SCORE, 5, score that ends the game immediately
SHOW_CYCLES, 4, settle cycles after a question index change before answers open
TIMEOUT_CYCLES, 1000, answer window length in cycles
RESULT_CYCLES, 8, hold cycles after a judgement
CNT_W, 16, width of the shared cycle timer

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle start/restart pulse
p1_valid  in  1  player 1 answer strobe, synchronous, one cycle
p1_ans  in  4  player 1 answer, BCD 1..4
p2_valid  in  1  player 2 answer strobe
p2_ans  in  4  player 2 answer
q_ans  in  4  expected answer for the current bcd_state, from the question table
bcd_state  out  4  current question index to the question table
armed  out  1  answer window open
p1_inc  out  1  one-cycle score pulse to player 1 LED counter
p2_inc  out  1  one-cycle score pulse to player 2 LED counter
p1_score  out  4  player 1 score 0..WIN_SCORE
p2_score  out  4  player 2 score
beep  out  1  wrong/timeout buzzer
busy  out  1  game in progress
game_over  out  1  game finished
winner  out  2  00 none, 01 P1, 10 P2, 11 tie; valid when game_over=1

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0; timer 0; lock flags 0; prio=P1.
- States: IDLE, SHOW, ARMED, JUDGE, RESULT, NEXT, DONE.
- IDLE/DONE + start: scores=0, bcd_state=0, locks cleared, game_over=0, -> SHOW. start in any other state is ignored.
- SHOW:
  - Timer counts SHOW_CYCLES, then -> ARMED with timer reloaded.
  - busy=1 in all states except IDLE and DONE.
- ARMED:
  - armed=1; timer decrements.
  - An unlocked player's valid is sampled at the clock edge and latched (player, answer); -> JUDGE.
  - Both unlocked and valid in the same cycle: the prio player wins; prio then flips to the other player. Loser's press is discarded.
  - Valid from a locked player, or in any state other than ARMED, is ignored.
  - Timer reaching 0 with no accepted press -> RESULT (timeout) with beep=1.
- JUDGE (exactly 1 cycle):
  - Correct (latched answer == q_ans): the winning player's score increments on the exiting edge; pX_inc=1 for exactly the first RESULT cycle; beep=0.
  - Wrong, other player still unlocked: lock the answering player; beep=1 for one cycle; return to ARMED without reloading the timer.
  - Wrong, other player already locked: beep=1 and -> RESULT.
- RESULT:
  - Holds RESULT_CYCLES. beep remains 1 throughout on the timeout and both-wrong paths; 0 otherwise.
  - -> NEXT.
- NEXT (1 cycle):
  - Either score == WIN_SCORE, or bcd_state == NUM_Q-1 -> DONE.
  - Otherwise bcd_state+1, locks cleared, -> SHOW.
- DONE:
  - game_over=1, busy=0.
  - winner: 01 if p1_score > p2_score; 10 if p2_score > p1_score; 11 if equal and nonzero; 00 if both 0.
  - bcd_state and scores hold.
- Scores saturate at WIN_SCORE; they never wrap.
- bcd_state never exceeds NUM_Q-1.
- Latency: a press in ARMED cycle n gives pX_inc high in cycle n+2.

Decomposition:
- Shared package: state encoding enum; winner codes; player index constants P1/P2.
- One natural sub-module: answer_arbiter, covering two-requester round-robin priority with lock masks, the latched grant and the latched answer.
- The FSM, timer and score registers stay in the top level.

Test Plan:
- Reset mid-ARMED (rst_n low for 1 cycle) -> all outputs 0, state IDLE; a following start -> bcd_state=0, armed after SHOW_CYCLES=4.
- P1 answers 1 with q_ans=1 at ARMED cycle n -> p1_inc high in cycle n+2 only, p1_score=1, bcd_state=1 after RESULT.
- Simultaneous p1_valid and p2_valid, both correct -> P1 wins and scores. On the next question, repeat the simultaneous press -> P2 wins.
- P1 answers wrong -> one-cycle beep, P1 locked. A further P1 press is ignored. P2 answers correct -> p2_score=1.
- No press for 1000 cycles -> beep high for 8 cycles, scores unchanged, bcd_state advances.
- Ten questions with P1 scoring 4 and P2 scoring 4 -> DONE after bcd_state=9, winner=11.
- P1 reaches 5 on question 6 -> DONE immediately, winner=01.
- start pulse during ARMED -> ignored.
